lut_cfg_loader: RTL and testbench

//  Configuration sequencer for a bank of fracturable LUTs (lut_sXX_softcode instances).
//  - Accepts a serial bitstream over a valid/ready handshake.
//  - Deserialises one config word (fracture bit + two LUT tables) per LUT.
//  - Commits each word with a one-cycle cen strobe to LUTs 0..NUM_LUTS-1, in order.
//  - Sits between the fabric's config port and the CLB's LUT config inputs, on cclk.

---
 rtl/lut_cfg_loader.sv | 97 +++++++++
 tb/tb_lut_cfg_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/lut_cfg_loader.sv
// Serial configuration loader for a bank of fracturable LUTs: deserialises one
// {use_fracture, first_lut, second_lut} word per LUT and commits it with a one-hot cen strobe.
module lut_cfg_loader #(
  parameter int INPUTS   = 4,
  parameter int MEM_SIZE = 2**INPUTS,
  parameter int CFG_W    = 2*MEM_SIZE+1,
  parameter int NUM_LUTS = 4,
  parameter int CNT_W    = $clog2(CFG_W+1),
  parameter int IDX_W    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic                cclk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cfg_bit,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic [CFG_W-1:0]    config_out,
  output logic [NUM_LUTS-1:0] cen,
  output logic                busy,
  output logic                done
);

  // Handshake: a cfg_bit transfers on a posedge where cfg_valid && cfg_ready;
  // cfg_ready is a registered flag, high only in LOAD, so the source never sees a
  // combinational dependency on its own valid.
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;

  state_t           state;
  logic [CFG_W-1:0] sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] lut_idx;

  assign config_out = sr;

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      lut_idx   <= '0;
      cfg_ready <= 1'b0;
      cen       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LOAD;
            bit_cnt   <= '0;
            lut_idx   <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            sr <= {sr[CFG_W-2:0], cfg_bit};
            // Last bit of the word: strobe the target LUT while sr holds still.
            if (bit_cnt == CNT_W'(CFG_W-1)) begin
              state     <= COMMIT;
              cfg_ready <= 1'b0;
              cen       <= NUM_LUTS'(1) << lut_idx;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        COMMIT: begin
          cen <= '0;
          if (lut_idx == IDX_W'(NUM_LUTS-1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state     <= LOAD;
            lut_idx   <= lut_idx + IDX_W'(1);
            bit_cnt   <= '0;
            cfg_ready <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
          cen       <= '0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Bench for lut_cfg_loader: a word-level model (expected word queue, bit stream,
// commit cycle arithmetic) checks every cen pulse, done, and reset behaviour.
module tb_lut_cfg_loader;

  localparam int INPUTS   = 4;
  localparam int MEM_SIZE = 2**INPUTS;
  localparam int CFG_W    = 2*MEM_SIZE+1;
  localparam int NUM_LUTS = 4;

  logic                cclk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                cfg_bit = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [CFG_W-1:0]    config_out;
  logic [NUM_LUTS-1:0] cen;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_errors = 0;
  logic [CFG_W-1:0] exp_q[$];

  lut_cfg_loader #(.INPUTS(INPUTS), .NUM_LUTS(NUM_LUTS)) dut (
    .cclk(cclk), .rst_n(rst_n), .start(start), .cfg_bit(cfg_bit),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .config_out(config_out),
    .cen(cen), .busy(busy), .done(done)
  );

  // clock / reset block
  always #5 cclk = ~cclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one complete load. Cycle c=0 is the cycle in which start is driven;
  // with valid held high, LUT k commits at cycle (k+1)*(CFG_W+1), done follows.
  task automatic run_load(input logic [CFG_W-1:0] w [NUM_LUTS], input int valid_pct,
                          input bit chk_timing, input int start_a, input int start_b);
    bit stream[$];
    int bit_idx = 0;
    int n_cen = 0;
    int done_c = -1;
    bit finished = 0;
    stream.delete();
    exp_q.delete();
    for (int k = 0; k < NUM_LUTS; k++) begin
      exp_q.push_back(w[k]);
      for (int b = CFG_W-1; b >= 0; b--) stream.push_back(w[k][b]);
    end
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge cclk);
      if (cen != '0) begin
        check("cen_onehot", 64'(cen), 64'(1) << n_cen);
        check("cen_vs_ready", 64'(cfg_ready), 64'd0);
        if (exp_q.size() > 0) check("config_out", 64'(config_out), 64'(exp_q.pop_front()));
        else check("extra_cen", 64'(cen), 64'd0);
        if (chk_timing) check("cen_cycle", 64'(c), 64'((n_cen+1)*(CFG_W+1)));
        n_cen++;
      end
      if (done) begin
        check("done_after_all_cen", 64'(n_cen), 64'(NUM_LUTS));
        if (done_c >= 0) check("done_twice", 64'd1, 64'd0);
        if (chk_timing) check("done_cycle", 64'(c), 64'(NUM_LUTS*(CFG_W+1)+1));
        done_c = c;
      end
      if (done_c >= 0 && c == done_c + 1) begin
        check("busy_after_done", 64'(busy), 64'd0);
        check("done_pulse_width", 64'(done), 64'd0);
        finished = 1;
      end
      // drive next cycle's inputs
      start = (c == 0) || (c == start_a) || (c == start_b);
      cfg_valid = (bit_idx < stream.size()) && ($urandom_range(99) < valid_pct);
      cfg_bit = cfg_valid ? stream[bit_idx] : 1'($urandom);
      if (cfg_valid && cfg_ready) bit_idx++;
    end
    start = 0;
    cfg_valid = 0;
    check("load_completed", 64'(finished), 64'd1);
    check("bits_consumed", 64'(bit_idx), 64'(stream.size()));
  endtask

  logic [CFG_W-1:0] words [NUM_LUTS];

  initial begin
    // 1: reset with random inputs
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); cfg_valid = 1'($urandom); cfg_bit = 1'($urandom);
      @(negedge cclk);
      check("rst_cen", 64'(cen), 64'd0);
      check("rst_ready", 64'(cfg_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_cfg", 64'(config_out), 64'd0);
    end
    start = 0; cfg_valid = 0;
    rst_n = 1;
    repeat (2) begin
      @(negedge cclk);
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_ready", 64'(cfg_ready), 64'd0);
      check("post_rst_cen", 64'(cen), 64'd0);
    end

    // 2: directed stream, valid held high, exact timing
    words[0] = 33'h1_0000_FFFF;
    for (int k = 1; k < NUM_LUTS; k++) words[k] = 33'h0_A5A5_3C3C;
    run_load(words, 100, 1, -1, -1);

    // 3: same stream, ~50% valid
    run_load(words, 50, 0, -1, -1);

    // 4: MSB-first ordering
    words[0] = 33'h1_0000_0000;
    for (int k = 1; k < NUM_LUTS; k++) words[k] = {1'($urandom), $urandom, $urandom};
    run_load(words, 100, 1, -1, -1);

    // 5: start pulses mid-load are ignored
    for (int k = 0; k < NUM_LUTS; k++) words[k] = {1'($urandom), $urandom};
    run_load(words, 100, 1, 5, 40);

    // random words with random stalls
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NUM_LUTS; k++) words[k] = {1'($urandom), $urandom};
      run_load(words, $urandom_range(20, 90), 0, $urandom_range(2, 200), -1);
    end

    // 6: reset after 10 bits of LUT0 aborts the load
    @(negedge cclk);
    start = 1;
    begin
      int xfers = 0;
      for (int c = 0; c < 100 && xfers < 10; c++) begin
        @(negedge cclk);
        start = 0;
        check("partial_no_cen", 64'(cen), 64'd0);
        cfg_valid = 1;
        cfg_bit = 1'($urandom);
        if (cfg_ready) xfers++;
      end
      check("partial_xfers", 64'(xfers), 64'd10);
    end
    @(negedge cclk);
    cfg_valid = 0;
    rst_n = 0;
    @(negedge cclk);
    check("abort_ready", 64'(cfg_ready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cen", 64'(cen), 64'd0);
    rst_n = 1;
    @(negedge cclk);
    check("abort_idle_cen", 64'(cen), 64'd0);
    words[0] = 33'h1_0000_FFFF;
    for (int k = 1; k < NUM_LUTS; k++) words[k] = 33'h0_A5A5_3C3C;
    run_load(words, 100, 1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
